// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, default widths, fetch FSM states and
// instruction field extractors.
package cpu_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic [4:0] OP_MVI = 5'b00001;
    localparam logic [4:0] OP_LD  = 5'b00100;
    localparam logic [4:0] OP_ST  = 5'b00101;

    typedef enum logic [2:0] {
        F_ISSUE,
        F_WAIT,
        I_ISSUE,
        I_WAIT,
        HOLD,
        D_WAIT
    } fetch_state_e;

    function automatic logic [4:0] f_opcode(input logic [31:0] w);
        return w[31:27];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[14:10];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[9:5];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[4:0];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch plus single-port RAM arbitration; execute-stage data
// accesses win the port over instruction fetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_word,
    output logic [4:0]        ins_opcode,
    output logic [DATA_W-1:0] ins_imm,
    output logic              ins_has_imm,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              dreq_valid,
    output logic              dreq_ready,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              drsp_valid,
    output logic [DATA_W-1:0] drsp_rdata
);

    fetch_state_e      state_q, state_d;
    logic              ret_hold_q, ret_hold_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ins_word_q, ins_word_d;
    logic [DATA_W-1:0] ins_imm_q, ins_imm_d;
    logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
    logic              dacc;

    // ins_valid also covers a load serviced while holding, so the offered
    // instruction never drops before its handshake.
    assign ins_valid   = (state_q == HOLD) || ((state_q == D_WAIT) && ret_hold_q);
    assign dreq_ready  = (state_q == F_ISSUE) || (state_q == HOLD);
    assign dacc        = dreq_valid && dreq_ready;
    assign ins_word    = ins_word_q;
    assign ins_opcode  = f_opcode(ins_word_q);
    assign ins_has_imm = (ins_opcode == OP_MVI);
    assign ins_imm     = ins_imm_q;
    assign ins_pc      = ins_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_ISSUE;
            ret_hold_q <= 1'b0;
            pc_q       <= RESET_PC;
            ins_word_q <= '0;
            ins_imm_q  <= '0;
            ins_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            ret_hold_q <= ret_hold_d;
            pc_q       <= pc_d;
            ins_word_q <= ins_word_d;
            ins_imm_q  <= ins_imm_d;
            ins_pc_q   <= ins_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_hold_d = ret_hold_q;
        pc_d       = pc_q;
        ins_word_d = ins_word_q;
        ins_imm_d  = ins_imm_q;
        ins_pc_d   = ins_pc_q;
        mem_wr_en  = 1'b0;
        mem_addr   = pc_q;
        mem_wdata  = '0;
        drsp_valid = 1'b0;
        drsp_rdata = '0;

        if (dacc) begin
            mem_addr  = dreq_addr;
            mem_wr_en = dreq_we;
            mem_wdata = dreq_wdata;
        end

        case (state_q)
            F_ISSUE: begin
                if (dacc) begin
                    if (!dreq_we) begin
                        state_d    = D_WAIT;
                        ret_hold_d = 1'b0;
                    end
                end else begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                ins_word_d = mem_rdata;
                ins_pc_d   = pc_q;
                ins_imm_d  = '0;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = (f_opcode(mem_rdata) == OP_MVI) ? I_ISSUE : HOLD;
            end
            I_ISSUE: begin
                state_d = I_WAIT;
            end
            I_WAIT: begin
                ins_imm_d = mem_rdata;
                pc_d      = pc_q + ADDR_W'(1);
                state_d   = HOLD;
            end
            HOLD: begin
                if (dacc && !dreq_we) begin
                    state_d    = D_WAIT;
                    ret_hold_d = !ins_ready;
                end else if (ins_ready) begin
                    state_d = F_ISSUE;
                end
            end
            D_WAIT: begin
                drsp_valid = 1'b1;
                drsp_rdata = mem_rdata;
                state_d    = (ret_hold_q && !ins_ready) ? HOLD : F_ISSUE;
            end
            default: begin
                state_d = F_ISSUE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal scenarios, then randomized traffic
// checked against an instruction-stream / memory model.
module tb_fetch_unit;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          mem_wr_en, ins_valid, ins_ready, ins_has_imm, dreq_valid, dreq_ready;
    logic          dreq_we, drsp_valid;
    logic [AW-1:0] mem_addr, ins_pc, dreq_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, ins_word, ins_imm, dreq_wdata, drsp_rdata;
    logic [4:0]    ins_opcode;

    logic          mem_wr_en2, ins_valid2, ins_has_imm2, dreq_ready2, drsp_valid2;
    logic [AW-1:0] mem_addr2, ins_pc2;
    logic [DW-1:0] mem_wdata2, mem_rdata2, ins_word2, ins_imm2, drsp_rdata2;
    logic [4:0]    ins_opcode2;
    logic          ins_ready2  = 1'b1;
    logic          dreq_valid2 = 1'b0;
    logic          dreq_we2    = 1'b0;
    logic [AW-1:0] dreq_addr2  = '0;
    logic [DW-1:0] dreq_wdata2 = '0;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'd0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word), .ins_opcode(ins_opcode),
        .ins_imm(ins_imm), .ins_has_imm(ins_has_imm), .ins_pc(ins_pc),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata)
    );

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'd1023)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_wr_en(mem_wr_en2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .ins_valid(ins_valid2), .ins_ready(ins_ready2), .ins_word(ins_word2), .ins_opcode(ins_opcode2),
        .ins_imm(ins_imm2), .ins_has_imm(ins_has_imm2), .ins_pc(ins_pc2),
        .dreq_valid(dreq_valid2), .dreq_ready(dreq_ready2), .dreq_we(dreq_we2),
        .dreq_addr(dreq_addr2), .dreq_wdata(dreq_wdata2),
        .drsp_valid(drsp_valid2), .drsp_rdata(drsp_rdata2)
    );

    // RAM images: the initial block fills img/img2, the RAM process copies them on img_load.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] ram2[1024];
    logic [DW-1:0] img [1024];
    logic [DW-1:0] img2[1024];
    logic          img_load = 1'b0;

    always @(posedge clk) begin
        if (img_load) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]  <= img[i];
                ram2[i] <= img2[i];
            end
        end else begin
            if (mem_wr_en)  ram[mem_addr]   <= mem_wdata;
            if (mem_wr_en2) ram2[mem_addr2] <= mem_wdata2;
        end
        mem_rdata  <= ram[mem_addr];
        mem_rdata2 <= ram2[mem_addr2];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_ins_valid"},   32'(ins_valid),   32'd0);
        chk({t, "_drsp_valid"},  32'(drsp_valid),  32'd0);
        chk({t, "_mem_wr_en"},   32'(mem_wr_en),   32'd0);
        chk({t, "_ins_has_imm"}, 32'(ins_has_imm), 32'd0);
        chk({t, "_ins_word"},    ins_word,         32'd0);
        chk({t, "_ins_imm"},     ins_imm,          32'd0);
        chk({t, "_drsp_rdata"},  drsp_rdata,       32'd0);
        chk({t, "_ins_pc"},      32'(ins_pc),      32'd0);
        chk({t, "_mem_addr"},    32'(mem_addr),    32'd0);
        chk({t, "_dreq_ready"},  32'(dreq_ready),  32'd1);
    endtask

    // ---------------- behavioural model + compare (randomized phase) ----------------
    logic          chk_en = 1'b0;
    logic [DW-1:0] ref_mem[1024];
    int            exp_pc, inv_cnt, extra;
    logic          fresh, pend;
    logic [DW-1:0] pend_data;

    always @(negedge clk) begin
        logic          dacc, mvi;
        logic [DW-1:0] w, imm;
        if (!rst_n || !chk_en) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = img[i];
            exp_pc  = 0;
            inv_cnt = 0;
            extra   = 0;
            fresh   = 1'b1;
            pend    = 1'b0;
        end else begin
            dacc = dreq_valid && dreq_ready;
            chk("rnd_drsp_valid", 32'(drsp_valid), 32'(pend));
            if (pend) chk("rnd_drsp_rdata", drsp_rdata, pend_data);
            pend = 1'b0;
            if (dacc) begin
                chk("rnd_acc_addr", 32'(mem_addr), 32'(dreq_addr));
                chk("rnd_acc_we", 32'(mem_wr_en), 32'(dreq_we));
                if (dreq_we) begin
                    chk("rnd_acc_wdata", mem_wdata, dreq_wdata);
                    ref_mem[dreq_addr] = dreq_wdata;
                end else begin
                    pend      = 1'b1;
                    pend_data = ref_mem[dreq_addr];
                end
            end else begin
                chk("rnd_idle_we", 32'(mem_wr_en), 32'd0);
                chk("rnd_idle_wdata", mem_wdata, 32'd0);
            end
            if (ins_valid) begin
                w   = ref_mem[exp_pc];
                mvi = (w[31:27] == 5'b00001);
                imm = mvi ? ref_mem[(exp_pc + 1) % 1024] : 32'd0;
                // Gap = fetch latency plus port cycles stolen by data accesses.
                if (fresh) begin
                    chk("rnd_latency", 32'(inv_cnt), 32'((mvi ? 4 : 2) + extra));
                    fresh = 1'b0;
                end
                chk("rnd_ins_word", ins_word, w);
                chk("rnd_ins_pc", 32'(ins_pc), 32'(exp_pc));
                chk("rnd_ins_has_imm", 32'(ins_has_imm), 32'(mvi));
                chk("rnd_ins_imm", ins_imm, imm);
                chk("rnd_ins_opcode", 32'(ins_opcode), 32'(w[31:27]));
                if (ins_ready) begin
                    exp_pc  = (exp_pc + (mvi ? 2 : 1)) % 1024;
                    fresh   = 1'b1;
                    inv_cnt = 0;
                    extra   = (dacc && !dreq_we) ? 1 : 0;
                end
            end else begin
                inv_cnt++;
                if (dacc) extra += dreq_we ? 1 : 2;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic          acc;
        logic [DW-1:0] w;
        rst_n = 1'b0; ins_ready = 1'b0; dreq_valid = 1'b0; dreq_we = 1'b0;
        dreq_addr = '0; dreq_wdata = '0;
        for (int i = 0; i < 1024; i++) begin img[i] = 32'd0; img2[i] = 32'd0; end
        img[0] = 32'h08000020; img[1] = 32'h70664892; img[2] = 32'h18000000;
        img[3] = 32'h20000000; img[4] = 32'h10000C41; img[5] = 32'h18000001;
        img[1023] = 32'h766E2C96;
        img2[1023] = 32'h08000000; img2[0] = 32'h12345678; img2[1] = 32'h18000000;
        img_load = 1'b1;
        @(posedge clk); #1 img_load = 1'b0;
        @(negedge clk);
        chk_rst("rst");

        // Directed: mvi then single-word instructions, hold, load, store.
        ins_ready = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("c0_addr", 32'(mem_addr), 32'd0);
        repeat (4) @(negedge clk);
        chk("c4_valid", 32'(ins_valid), 32'd1);
        chk("c4_word", ins_word, 32'h08000020);
        chk("c4_has_imm", 32'(ins_has_imm), 32'd1);
        chk("c4_imm", ins_imm, 32'h70664892);
        chk("c4_pc", 32'(ins_pc), 32'd0);
        @(negedge clk);
        chk("c5_addr", 32'(mem_addr), 32'd2);
        chk("c5_valid", 32'(ins_valid), 32'd0);
        repeat (6) @(negedge clk);
        ins_ready = 1'b0;
        chk("c11_addr", 32'(mem_addr), 32'd4);
        @(negedge clk);
        chk("c12_valid", 32'(ins_valid), 32'd0);
        @(negedge clk);
        chk("c13_valid", 32'(ins_valid), 32'd1);
        chk("c13_word", ins_word, 32'h10000C41);
        chk("c13_opcode", 32'(ins_opcode), 32'd2);
        chk("c13_has_imm", 32'(ins_has_imm), 32'd0);
        chk("c13_imm", ins_imm, 32'd0);
        chk("c13_pc", 32'(ins_pc), 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ins_valid), 32'd1);
            chk("hold_word", ins_word, 32'h10000C41);
            chk("hold_pc", 32'(ins_pc), 32'd4);
            chk("hold_addr", 32'(mem_addr), 32'd5);
            chk("hold_we", 32'(mem_wr_en), 32'd0);
        end
        dreq_valid = 1'b1; dreq_we = 1'b0; dreq_addr = 10'd1023;
        #1;
        chk("ld_ready", 32'(dreq_ready), 32'd1);
        chk("ld_addr", 32'(mem_addr), 32'd1023);
        @(negedge clk);
        chk("ld_rsp_valid", 32'(drsp_valid), 32'd1);
        chk("ld_rsp_data", drsp_rdata, 32'h766E2C96);
        chk("ld_ins_valid", 32'(ins_valid), 32'd1);
        dreq_valid = 1'b0;
        @(negedge clk);
        chk("ld_rsp_done", 32'(drsp_valid), 32'd0);
        chk("ld_hold_valid", 32'(ins_valid), 32'd1);
        dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 10'd438; dreq_wdata = 32'h766E2C96;
        #1;
        chk("st_we", 32'(mem_wr_en), 32'd1);
        chk("st_addr", 32'(mem_addr), 32'd438);
        chk("st_wdata", mem_wdata, 32'h766E2C96);
        @(negedge clk);
        dreq_valid = 1'b0; dreq_we = 1'b0;
        #1;
        chk("st_we_off", 32'(mem_wr_en), 32'd0);
        chk("st_ram", ram[438], 32'h766E2C96);
        chk("st_hold_valid", 32'(ins_valid), 32'd1);
        ins_ready = 1'b1; dreq_valid = 1'b1; dreq_addr = 10'd1023;
        #1;
        chk("both_ready", 32'(dreq_ready), 32'd1);
        chk("both_addr", 32'(mem_addr), 32'd1023);
        @(negedge clk);
        chk("both_rsp_valid", 32'(drsp_valid), 32'd1);
        chk("both_rsp_data", drsp_rdata, 32'h766E2C96);
        chk("both_ins_valid", 32'(ins_valid), 32'd0);
        dreq_valid = 1'b0; ins_ready = 1'b0;
        @(negedge clk);
        chk("both_next_addr", 32'(mem_addr), 32'd5);
        chk("both_next_valid", 32'(ins_valid), 32'd0);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if ($urandom_range(3) == 0) w[31:27] = 5'b00001;
            else if (w[31:27] == 5'b00001) w[31:27] = 5'b00010;
            img[i] = w;
        end
        img_load = 1'b1;
        @(posedge clk); #1 img_load = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = dreq_valid && dreq_ready;
            @(posedge clk); #1;
            ins_ready = ($urandom_range(3) != 0);
            if (!dreq_valid || acc) begin
                dreq_valid = ($urandom_range(3) == 0);
                dreq_we    = $urandom_range(1) == 1;
                dreq_addr  = dreq_we ? AW'(768 + $urandom_range(255)) : AW'($urandom_range(1023));
                dreq_wdata = $urandom;
            end
        end
        chk_en = 1'b0; dreq_valid = 1'b0; ins_ready = 1'b1;

        // RESET_PC=1023 with an mvi there: immediate wraps to address 0.
        rst_n = 1'b0;
        img[0] = 32'h08000020; img[1] = 32'h70664892;
        img_load = 1'b1;
        @(posedge clk); #1 img_load = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("w_c0_addr1", 32'(mem_addr), 32'd0);
        chk("w_c0_addr2", 32'(mem_addr2), 32'd1023);
        repeat (2) @(negedge clk);
        chk("w_c2_addr2", 32'(mem_addr2), 32'd0);
        repeat (2) @(negedge clk);
        chk("w_c4_valid2", 32'(ins_valid2), 32'd1);
        chk("w_c4_word2", ins_word2, 32'h08000000);
        chk("w_c4_imm2", ins_imm2, 32'h12345678);
        chk("w_c4_pc2", 32'(ins_pc2), 32'd1023);
        @(negedge clk);
        chk("w_c5_addr2", 32'(mem_addr2), 32'd1);

        // Reset asserted during I_WAIT.
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_c3_word", ins_word, 32'h08000020);
        chk("mr_c3_valid", 32'(ins_valid), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_rst("midrst");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_c0_addr", 32'(mem_addr), 32'd0);
        repeat (4) @(negedge clk);
        chk("mr_c4_valid", 32'(ins_valid), 32'd1);
        chk("mr_c4_imm", ins_imm, 32'h70664892);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and memory-port arbitration stage that sits directly in front of the 1024×32 single-port program/data RAM. It owns the RAM's single port (`wr_en`, `address`, `data_in`, `data_out`) and walks a program counter through memory. It fetches the trailing immediate word of two-word `mvi` instructions and presents each complete instruction to the execute stage through a valid/ready handshake. Execute-stage load/store requests are interleaved onto the same port with priority over instruction fetch.

## Interface
- `ADDR_W`, 10, RAM word-address width
- `DATA_W`, 32, word width
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, reset asynchronous active-low
- `mem_wr_en`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after a read address is presented
- `ins_valid`  out  1  instruction available
- `ins_ready`  in  1  execute stage accepts instruction
- `ins_word`  out  DATA_W  instruction word
- `ins_opcode`  out  5  `ins_word[31:27]`
- `ins_imm`  out  DATA_W  immediate word; 0 when `ins_has_imm`=0
- `ins_has_imm`  out  1  instruction is `mvi` (opcode 5'b00001)
- `ins_pc`  out  ADDR_W  address of the instruction word
- `dreq_valid`  in  1  data access request
- `dreq_ready`  out  1  request accepted this cycle
- `dreq_we`  in  1  1 = store, 0 = load
- `dreq_addr`  in  ADDR_W  data address
- `dreq_wdata`  in  DATA_W  store data
- `drsp_valid`  out  1  load data valid, one-cycle pulse
- `drsp_rdata`  out  DATA_W  load data

## Operation
- FSM states: F_ISSUE, F_WAIT, I_ISSUE, I_WAIT, HOLD, D_WAIT. A 1-bit return register (F_ISSUE or HOLD) records where D_WAIT returns to.
- **F_ISSUE**
  - `dreq_ready`=1.
  - If `dreq_valid`: serve the data access (below); no fetch this cycle.
  - Otherwise: `mem_addr`=pc, `mem_wr_en`=0, next state F_WAIT.
- **F_WAIT**
  - Latch `ins_word`←`mem_rdata`, `ins_pc`←pc; pc←pc+1.
  - Opcode 5'b00001 → I_ISSUE; any other opcode → HOLD with `ins_imm`←0.
- **I_ISSUE**: `mem_addr`=pc, read; → I_WAIT. Data requests are not accepted (`dreq_ready`=0).
- **I_WAIT**: `ins_imm`←`mem_rdata`, pc←pc+1, → HOLD.
- **HOLD**
  - `ins_valid`=1, `dreq_ready`=1.
  - `ins_valid` and all `ins_*` fields stay stable until `ins_valid && ins_ready`.
  - A data access may be served while holding, so the execute stage can finish a load before accepting the next instruction.
- **Data access** (`dreq_valid && dreq_ready`)
  - `mem_addr`=`dreq_addr`, `mem_wr_en`=`dreq_we`, `mem_wdata`=`dreq_wdata`.
  - Store: completes in that cycle; state unchanged, or F_ISSUE if the instruction handshake also completed.
  - Load: → D_WAIT.
- **D_WAIT**: `drsp_valid`=1, `drsp_rdata`=`mem_rdata`; → return state.
- **HOLD with `ins_ready` and `dreq_valid` in the same cycle**: both handshakes complete; return target is F_ISSUE.
- Memory outputs are combinational from state and inputs. In all non-access states: `mem_wr_en`=0, `mem_addr`=pc, `mem_wdata`=0.
- pc arithmetic is modulo 2^ADDR_W: 1023+1 → 0. An `mvi` at address 1023 takes its immediate from address 0.

## Timing
- Reset (async assert, sync release):
  - State F_ISSUE, pc=`RESET_PC`.
  - `ins_valid`, `drsp_valid`, `mem_wr_en`, `ins_has_imm` = 0; `ins_word`, `ins_imm`, `drsp_rdata`, `ins_pc` = 0.
  - `mem_addr`=`RESET_PC`, `dreq_ready`=1.
- Reset mid-operation discards any held instruction and pending load response with no response pulse.
- Single-word instruction: address issued cycle N, `ins_valid` at N+2.
- `mvi`: address issued cycle N, `ins_valid` at N+4.
- Throughput with `ins_ready`=1 and no data traffic: one instruction per 3 cycles, or per 5 cycles for `mvi`.
- Load: accepted cycle N, `drsp_valid` at N+1. Store: written at the rising edge ending cycle N.

## Structure
- Shared `cpu_pkg` holds:
  - opcode constants (`OP_MVI`=5'b00001, `OP_LD`=5'b00100, `OP_ST`=5'b00101, …)
  - `ADDR_W`/`DATA_W` defaults
  - the fetch-state enum
  - field-extract functions for `[31:27]`, `[14:10]`, `[9:5]`, `[4:0]`
- Single module, no sub-module; the arbiter and FSM are inseparable.

## Test plan
- Reset, RAM word0=0x08000020, word1=0x70664892, `ins_ready`=1 → `ins_valid` at cycle 4 with `ins_word`=0x08000020, `ins_has_imm`=1, `ins_imm`=0x70664892, `ins_pc`=0; next fetch address 2.
- Word4=0x10000C41 → `ins_has_imm`=0, `ins_imm`=0, `ins_opcode`=5'b00010, `ins_valid` 2 cycles after address 4 is issued.
- Hold `ins_ready`=0 for 5 cycles in HOLD → `ins_*` stable; no RAM reads issued; pc unchanged.
- In HOLD, load from 1023 (RAM=0x766E2C96) → `drsp_valid` next cycle with 0x766E2C96; `ins_valid` stays 1. Then store 0x766E2C96 to 438 → `mem_wr_en`=1 for exactly one cycle, address 438.
- Same-cycle `ins_ready` and load request in HOLD → load serviced, `drsp_valid` next cycle, then F_ISSUE fetches the next pc.
- `RESET_PC`=1023 with an `mvi` there → immediate read from address 0; next fetch at address 1.
- `rst_n` low during I_WAIT → all outputs return to reset values immediately; first fetch at `RESET_PC` after release.
